// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU request, auxiliary request and memory-control signals
// of the mem_arbiter. The shared data bus Mem_Bus is a separate inout net.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_cs;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_busy;
  logic              aux_done;
  logic [DATA_W-1:0] aux_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              cpu_hold;

  // Arbiter side.
  modport slave (
    input  cpu_cs, cpu_we, cpu_addr,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_busy, aux_done, aux_rdata,
    output mem_cs, mem_we, mem_addr,
    output cpu_hold
  );

  // Requester / environment side.
  modport master (
    output cpu_cs, cpu_we, cpu_addr,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_busy, aux_done, aux_rdata,
    input  mem_cs, mem_we, mem_addr,
    input  cpu_hold
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Memory instance between the CPU (fixed priority)
// and an auxiliary requester that uses idle memory cycles.
// Optional feature macro: ARB_STARVE_GUARD_EN -- counts denied auxiliary
// cycles and raises cpu_hold after MAX_WAIT of them so the request completes.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  mem_arbiter_if.slave      bus,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  // Elaboration-time range check on the wait limit.
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              accept_c;
  logic              complete_c;
  logic              aux_own_c;
  logic              hold_c;

  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              aux_done_q;
  logic [DATA_W-1:0] aux_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              cpu_hold_q;
  logic              cpu_hold_d;

  assign hold_c = cpu_hold_q;
`else
  assign hold_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, cycle ownership and (optionally) the starvation counter.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    aux_own_c  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    wait_cnt_d = wait_cnt_q;
    cpu_hold_d = cpu_hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.aux_req) begin
          state_d  = ACCESS;
          accept_c = 1'b1;
        end
      end
      ACCESS: begin
        aux_own_c = ~bus.cpu_cs | hold_c;
        if (aux_own_c) begin
          state_d    = IDLE;
          complete_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_STARVE_GUARD_EN
    if (accept_c) begin
      wait_cnt_d = '0;
      cpu_hold_d = 1'b0;
    end else if (complete_c) begin
      cpu_hold_d = 1'b0;
    end else if (state_q == ACCESS) begin
      // Denied cycle: the CPU took the memory.
      wait_cnt_d = CNT_W'(wait_cnt_q + CNT_W'(1));
      if (wait_cnt_d == WAIT_LIMIT) begin
        cpu_hold_d = 1'b1;
      end
    end
`endif
  end

  // Request capture, completion pulse and read-data return.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      aux_done_q  <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      aux_done_q <= complete_c;
      if (accept_c) begin
        lat_we_q    <= bus.aux_we;
        lat_addr_q  <= bus.aux_addr;
        lat_wdata_q <= bus.aux_wdata;
      end
      if (complete_c && !lat_we_q) begin
        aux_rdata_q <= Mem_Bus;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Denied-cycle counter and CPU hold request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= '0;
      cpu_hold_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end
`endif

  // Memory-side mux: aux owns the cycle, otherwise the CPU passes through.
  assign bus.mem_cs   = aux_own_c ? 1'b1        : bus.cpu_cs;
  assign bus.mem_we   = aux_own_c ? lat_we_q    : bus.cpu_we;
  assign bus.mem_addr = aux_own_c ? lat_addr_q  : bus.cpu_addr;

  // Drive write data only in an aux-owned write cycle.
  assign Mem_Bus = (aux_own_c && lat_we_q) ? lat_wdata_q : {DATA_W{1'bz}};

  assign bus.aux_busy  = (state_q == ACCESS);
  assign bus.aux_done  = aux_done_q;
  assign bus.aux_rdata = aux_rdata_q;
  assign bus.cpu_hold  = hold_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (expected completion cycle and memory contents).
module tb_mem_arbiter;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 128;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  wire  [DATA_W-1:0] Mem_Bus;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .Mem_Bus (Mem_Bus)
  );

  always #5 CLK = ~CLK;

  // A released bus floats high, so "released" is observable as all ones.
  pullup (Mem_Bus);

  // Memory stand-in: access on the negedge, read data held until the posedge.
  logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_q = '0;
  logic              rd_en = 1'b0;
  always @(CLK) begin
    if (!CLK) begin
      if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] = Mem_Bus;
      rd_q  <= ram[bus.mem_addr];
      rd_en <= bus.mem_cs && !bus.mem_we;
    end else begin
      rd_en <= 1'b0;
    end
  end
  assign Mem_Bus = rd_en ? rd_q : {DATA_W{1'bz}};

  // CPU drives write data in its own write cycles unless frozen.
  logic [DATA_W-1:0] cpu_wdata = '0;
  assign Mem_Bus = (bus.cpu_cs && bus.cpu_we && !bus.cpu_hold) ? cpu_wdata : {DATA_W{1'bz}};

  // Reference model state.
  logic [DATA_W-1:0] model_ram [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] exp_rdata = '0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: inputs set just after a posedge, memory side sampled mid-cycle.
  task automatic cpu_cycle(input logic cs, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d,
                           output logic o_cs, output logic o_we,
                           output logic [ADDR_W-1:0] o_a, output logic [DATA_W-1:0] o_bus);
    bus.cpu_cs   = cs;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    cpu_wdata    = d;
    @(negedge CLK); #2;
    o_cs  = bus.mem_cs;
    o_we  = bus.mem_we;
    o_a   = bus.mem_addr;
    o_bus = Mem_Bus;
    @(posedge CLK); #1;
  endtask

  // Plain CPU access with no auxiliary activity.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic ocs, owe;
    logic [ADDR_W-1:0] oa;
    logic [DATA_W-1:0] ob;
    cpu_cycle(1'b1, we, a, d, ocs, owe, oa, ob);
    chk("cpu_addr_pass", 32'(oa), 32'(a));
    if (we) model_ram[a] = d;
    else    chk("cpu_rd", ob, model_ram[a]);
  endtask

  // Auxiliary transaction with the CPU busy for k cycles after the request.
  task automatic aux_txn(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int unsigned k);
    int unsigned own_idx;
    logic ocs, owe, cs, cw;
    logic [ADDR_W-1:0] oa, ca;
    logic [DATA_W-1:0] ob, cd;
    own_idx = (GUARD && k > MAX_WAIT) ? MAX_WAIT + 1 : k + 1;
    bus.aux_req   = 1'b1;
    bus.aux_we    = we;
    bus.aux_addr  = a;
    bus.aux_wdata = d;
    cpu_cycle(1'b0, 1'b0, '0, '0, ocs, owe, oa, ob);
    chk("busy_after_req", 32'(bus.aux_busy), 32'(1));
    chk("no_done_at_req", 32'(bus.aux_done), 32'(0));
    for (int i = 1; i <= int'(own_idx); i++) begin
      cs = (i <= int'(k));
      cw = 1'($urandom);
      ca = ADDR_W'($urandom);
      cd = $urandom;
      // Auxiliary inputs change while busy and must be ignored.
      bus.aux_req   = 1'($urandom);
      bus.aux_we    = 1'($urandom);
      bus.aux_addr  = ADDR_W'($urandom);
      bus.aux_wdata = $urandom;
      cpu_cycle(cs, cw, ca, cd, ocs, owe, oa, ob);
      if (i < int'(own_idx)) begin
        chk("deny_addr", 32'(oa), 32'(ca));
        chk("deny_cs", 32'(ocs), 32'(1));
        if (cw) model_ram[ca] = cd;
        else    chk("cpu_rd_collide", ob, model_ram[ca]);
      end else begin
        chk("own_addr", 32'(oa), 32'(a));
        chk("own_cs", 32'(ocs), 32'(1));
        chk("own_we", 32'(owe), 32'(we));
        if (we) begin
          chk("own_wdata", ob, d);
          model_ram[a] = d;
        end else begin
          exp_rdata = model_ram[a];
        end
      end
      chk("done", 32'(bus.aux_done), 32'(i == int'(own_idx)));
      chk("busy", 32'(bus.aux_busy), 32'(i < int'(own_idx)));
      chk("hold", 32'(bus.cpu_hold), 32'(GUARD && k >= MAX_WAIT && i == int'(MAX_WAIT)));
    end
    bus.aux_req = 1'b0;
    chk("rdata", bus.aux_rdata, exp_rdata);
  endtask

  initial begin
    logic ocs, owe;
    logic [ADDR_W-1:0] oa;
    logic [DATA_W-1:0] ob;

    bus.cpu_cs    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.aux_req   = 1'b0;
    bus.aux_we    = 1'b0;
    bus.aux_addr  = '0;
    bus.aux_wdata = '0;

    // Power-on reset state.
    #12;
    chk("rst_busy", 32'(bus.aux_busy), 32'(0));
    chk("rst_done", 32'(bus.aux_done), 32'(0));
    chk("rst_rdata", bus.aux_rdata, 32'(0));
    chk("rst_hold", 32'(bus.cpu_hold), 32'(0));
    chk("rst_bus_released", Mem_Bus, 32'hFFFF_FFFF);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Idle-CPU aux read of a preloaded word.
    cpu_op(1'b1, 7'd5, 32'hDEAD_BEEF);
    aux_txn(1'b0, 7'd5, '0, 0);
    chk("read_deadbeef", bus.aux_rdata, 32'hDEAD_BEEF);

    // Aux write, then a CPU read of the same word.
    aux_txn(1'b1, 7'd7, 32'h0000_1234, 0);
    cpu_op(1'b0, 7'd7, '0);

    // Collision: CPU busy for three cycles after the request.
    aux_txn(1'b0, 7'd7, '0, 3);
    chk("collide_rdata", bus.aux_rdata, 32'h0000_1234);

    // Long CPU activity: held off after MAX_WAIT denials, or waits throughout.
    aux_txn(1'b1, 7'd20, 32'hCAFE_0020, 10);
    cpu_op(1'b0, 7'd20, '0);

    // Back-to-back requests.
    aux_txn(1'b0, 7'd20, '0, 0);
    aux_txn(1'b1, 7'd21, 32'h0BAD_F00D, MAX_WAIT);
    aux_txn(1'b0, 7'd21, '0, 1);

    // Reset during an owned write cycle to address 9.
    cpu_op(1'b1, 7'd9, 32'hA5A5_0009);
    bus.aux_req   = 1'b1;
    bus.aux_we    = 1'b1;
    bus.aux_addr  = 7'd9;
    bus.aux_wdata = 32'h1111_2222;
    cpu_cycle(1'b0, 1'b0, '0, '0, ocs, owe, oa, ob);
    bus.aux_req  = 1'b0;
    bus.cpu_cs   = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 7'h33;
    #1;
    chk("pre_rst_own_addr", 32'(bus.mem_addr), 32'(9));
    chk("pre_rst_bus", Mem_Bus, 32'h1111_2222);
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.aux_busy), 32'(0));
    chk("mid_rst_done", 32'(bus.aux_done), 32'(0));
    chk("mid_rst_rdata", bus.aux_rdata, 32'(0));
    chk("mid_rst_hold", 32'(bus.cpu_hold), 32'(0));
    chk("mid_rst_mem_cs", 32'(bus.mem_cs), 32'(0));
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h33);
    chk("mid_rst_bus_released", Mem_Bus, 32'hFFFF_FFFF);
    exp_rdata = '0;
    @(posedge CLK); #1;
    chk("rst_no_done", 32'(bus.aux_done), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_idle", 32'(bus.aux_busy), 32'(0));
    chk("post_rst_no_done", 32'(bus.aux_done), 32'(0));
    cpu_op(1'b0, 7'd9, '0);

    // Randomized transactions interleaved with CPU traffic.
    for (int t = 0; t < 24; t++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        cpu_op(1'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom);
      end
      aux_txn(1'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom, $urandom_range(0, 7));
    end

    // Final sweep of the low addresses through CPU reads.
    for (int a = 0; a < 16; a++) begin
      cpu_op(1'b0, ADDR_W'(a), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 128x32 `Memory` instance between the MIPS CPU and an auxiliary requester, such as a display scanner or a debug/DMA loader. It sits between CPU and memory, muxing `CS`/`WE`/`ADDR` and driving `Mem_Bus` for auxiliary writes. The CPU has fixed priority. Auxiliary accesses use idle memory cycles, with an optional anti-starvation hold.

## Interface
Parameters:
- `ADDR_W`, 7: memory word-address width.
- `DATA_W`, 32: memory word width.
- `MAX_WAIT`, 8: cycles an auxiliary request may be denied before `cpu_hold` is asserted. Used only with `ARB_STARVE_GUARD_EN`. Range 1..255.

Ports:
- `CLK`  in  1  system clock. All state updates on the posedge.
- `RST`  in  1  reset, asynchronous, active-high.
- `cpu_cs`  in  1  CPU chip select (combinational from the CPU FSM).
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `aux_req`  in  1  auxiliary request. Sampled only while `aux_busy`=0.
- `aux_we`  in  1  auxiliary write (1) or read (0). Latched with the request.
- `aux_addr`  in  ADDR_W  auxiliary address. Latched with the request.
- `aux_wdata`  in  DATA_W  auxiliary write data. Latched with the request.
- `aux_busy`  out  1  a request is latched and not yet done.
- `aux_done`  out  1  one-cycle completion pulse.
- `aux_rdata`  out  DATA_W  read data. Valid from `aux_done` until the next done.
- `mem_cs`, `mem_we`  out  1  to `Memory` CS/WE.
- `mem_addr`  out  ADDR_W  to `Memory` ADDR.
- `Mem_Bus`  inout  DATA_W  shared memory data bus.
- `cpu_hold`  out  1  CPU must freeze state and PC and not drive `Mem_Bus`. Constant 0 without the macro.

## Operation
- FSM has two states:
  - IDLE: `aux_busy`=0.
  - ACCESS: `aux_busy`=1.
- IDLE to ACCESS: at the posedge where `aux_req`=1. On that edge `aux_we`/`aux_addr`/`aux_wdata` are captured into registers.
- Memory-side mux (combinational), an aux-owned cycle being `aux_own`:
  - `aux_own` = ACCESS & (~`cpu_cs` | `cpu_hold`).
  - If `aux_own`: `mem_cs`=1, `mem_we`=latched we, `mem_addr`=latched addr.
  - Otherwise: `mem_cs`/`mem_we`/`mem_addr` = `cpu_cs`/`cpu_we`/`cpu_addr`.
- `Mem_Bus` drive: latched wdata only when `aux_own` & latched we. Otherwise Z. The CPU and the memory drive it in their own cycles.
- ACCESS to IDLE: at a posedge ending an `aux_own` cycle.
  - That edge pulses `aux_done`.
  - On a read, `Mem_Bus` is captured into `aux_rdata`.
- ACCESS cycles with `cpu_cs`=1 and no hold are denied. The FSM stays in ACCESS and the request retries on the next cycle.
- A new `aux_req` is accepted the posedge after `aux_done` at the earliest. `aux_req` held high therefore yields back-to-back accesses.
- Simultaneous events:
  - `cpu_cs`=1 in ACCESS always wins unless `cpu_hold`=1.
  - `aux_req` while busy is ignored.

## Timing
- Reset values, applied immediately and asynchronously:
  - FSM = IDLE.
  - `aux_busy`=0, `aux_done`=0, `aux_rdata`=0, `cpu_hold`=0.
  - Wait counter = 0.
  - Latched registers = 0.
  - `mem_*` follow the CPU inputs.
  - `Mem_Bus` released.
- Memory reads and writes occur on the negedge inside the owned cycle. Read data is on `Mem_Bus` in the second half of that cycle.
- Minimum latency: request edge, then one owned cycle, then `aux_done` at the following posedge. That is 2 posedges from request sample to done.
- Reset mid-ACCESS cancels the request with no `aux_done`. If `RST` rises before that cycle's negedge, the auxiliary write does not occur.
- `aux_rdata` is unchanged by writes.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - An 8-bit wait counter counts denied ACCESS cycles. It clears on entry to ACCESS and on reset.
  - When the count reaches `MAX_WAIT`, `cpu_hold` is registered high at that posedge.
  - The next cycle is owned by aux regardless of `cpu_cs`.
  - `cpu_hold` clears at the posedge that completes the access.
- Not defined:
  - No counter.
  - `cpu_hold` is constant 0.
  - An auxiliary request waits indefinitely while the CPU keeps `cpu_cs` high.

## Test plan
- Reset: assert `RST` mid-cycle -> `aux_busy`=0, `aux_done`=0, `aux_rdata`=0, `cpu_hold`=0 before the next posedge; `Mem_Bus` = Z.
- Idle-CPU aux read: `cpu_cs`=0, RAM[5]=32'hDEADBEEF, `aux_req` (we=0, addr=5) for one cycle -> `aux_done` 2 posedges later with `aux_rdata`=32'hDEADBEEF.
- Aux write, then CPU fetch: aux write 32'h0000_1234 to addr 7 -> `aux_done`; a later CPU read of addr 7 returns 32'h0000_1234.
- Collision: `cpu_cs`=1 for 3 cycles after the aux request -> `mem_addr` equals `cpu_addr` in those cycles; `aux_done` arrives on the 4th owned edge; CPU data is unaffected.
- Starvation (macro on, `MAX_WAIT`=4): `cpu_cs` held at 1 -> `cpu_hold` rises after 4 denied cycles; the access completes one cycle later; `cpu_hold` falls at `aux_done`.
- Reset during ACCESS with a write to addr 9: `RST` rises before the negedge -> RAM[9] is unchanged, no `aux_done`, FSM in IDLE.
